alu_seq: RTL

- Parametrised, registered successor to the 8-bit combinational ALU.
- Supports WIDTH-bit operands and the same 16-entry FunSel map.
- Shift and rotate ops take a variable shift amount taken from B and execute iteratively, one bit per cycle, under a START/BUSY/DONE handshake.
- Sits between the register file and the datapath bus; the controller issues one op per START.

---
 rtl/alu_pkg.sv | 37 +++
 rtl/alu_seq_shift_step.sv | 49 ++++
 rtl/alu_seq.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: op codes, flag bit positions, FSM states.
package alu_pkg;

    localparam logic [3:0] FS_A    = 4'h0;
    localparam logic [3:0] FS_B    = 4'h1;
    localparam logic [3:0] FS_NOTA = 4'h2;
    localparam logic [3:0] FS_NOTB = 4'h3;
    localparam logic [3:0] FS_ADD  = 4'h4;
    localparam logic [3:0] FS_ADC  = 4'h5;
    localparam logic [3:0] FS_CMP  = 4'h6;
    localparam logic [3:0] FS_AND  = 4'h7;
    localparam logic [3:0] FS_OR   = 4'h8;
    localparam logic [3:0] FS_XOR  = 4'h9;
    localparam logic [3:0] FS_LSL  = 4'hA;
    localparam logic [3:0] FS_LSR  = 4'hB;
    localparam logic [3:0] FS_ASL  = 4'hC;
    localparam logic [3:0] FS_ASR  = 4'hD;
    localparam logic [3:0] FS_CSL  = 4'hE;
    localparam logic [3:0] FS_CSR  = 4'hF;

    localparam int unsigned FLG_Z = 3;
    localparam int unsigned FLG_C = 2;
    localparam int unsigned FLG_N = 1;
    localparam int unsigned FLG_O = 0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Shift and rotate ops occupy the top six codes
    function automatic logic is_shift(input logic [3:0] fs);
        return fs >= FS_LSL;
    endfunction

endpackage

// File: rtl/alu_seq_shift_step.sv
// One-bit shift/rotate step shared by all iterative shift cycles.
module alu_shift_step
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] val,
    input  logic [3:0]       op,
    output logic [WIDTH-1:0] nxt,
    output logic             bit_out,
    output logic             sign_chg
);

    // Single-bit move; sign_chg reports an ASL step that flips the MSB
    always_comb begin
        nxt      = val;
        bit_out  = 1'b0;
        sign_chg = 1'b0;
        case (op)
            FS_LSL: begin
                nxt     = {val[WIDTH-2:0], 1'b0};
                bit_out = val[WIDTH-1];
            end
            FS_LSR: begin
                nxt     = {1'b0, val[WIDTH-1:1]};
                bit_out = val[0];
            end
            FS_ASL: begin
                nxt      = {val[WIDTH-2:0], 1'b0};
                bit_out  = val[WIDTH-1];
                sign_chg = val[WIDTH-1] ^ val[WIDTH-2];
            end
            FS_ASR: begin
                nxt     = {val[WIDTH-1], val[WIDTH-1:1]};
                bit_out = val[0];
            end
            FS_CSL: begin
                nxt     = {val[WIDTH-2:0], val[WIDTH-1]};
                bit_out = val[WIDTH-1];
            end
            FS_CSR: begin
                nxt     = {val[0], val[WIDTH-1:1]};
                bit_out = val[0];
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/alu_seq.sv
// Registered ALU with iterative shifts under a START/BUSY/DONE handshake.
// Optional build macro ALU_SAT_EN: add/adc/compare saturate on signed overflow.
module alu_seq
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RSTn,
    input  logic             START,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       FunSel,
    output logic [WIDTH-1:0] OutALU,
    output logic [3:0]       ZCNO,
    output logic             BUSY,
    output logic             DONE
);

    localparam int unsigned SHAMT_W = $clog2(WIDTH);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [3:0]         fs_q, fs_d;
    logic [SHAMT_W-1:0] cnt_q, cnt_d;
    logic               chg_q, chg_d;
    logic [WIDTH-1:0]   out_q, out_d;
    logic [3:0]         flags_q, flags_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic [SHAMT_W-1:0] amt;
    logic               in_shift;
    logic [WIDTH-1:0]   step_in, step_nxt;
    logic [3:0]         step_op;
    logic               step_out, step_chg, fin_chg;

    logic [WIDTH-1:0]   opb, ar_res, alu_res;
    logic               cin, ovf;
    logic [WIDTH:0]     sum;
    logic [3:0]         alu_flags, sh_flags, z0_flags;

    assign amt      = B[SHAMT_W-1:0];
    assign in_shift = (state_q == ST_SHIFT);

    // The first step runs on the accept edge from the live inputs, later steps from the work register
    assign step_in  = in_shift ? a_q : A;
    assign step_op  = in_shift ? fs_q : FunSel;
    assign fin_chg  = step_chg | (in_shift & chg_q);

    alu_shift_step #(.WIDTH(WIDTH)) u_step (
        .val      (step_in),
        .op       (step_op),
        .nxt      (step_nxt),
        .bit_out  (step_out),
        .sign_chg (step_chg)
    );

    // Single-cycle result and flags; add/sub evaluated at WIDTH+1 bits
    always_comb begin
        opb    = (FunSel == FS_CMP) ? ~B : B;
        cin    = (FunSel == FS_CMP) ? 1'b1 :
                 (FunSel == FS_ADC) ? flags_q[FLG_C] : 1'b0;
        sum    = {1'b0, A} + {1'b0, opb} + {{WIDTH{1'b0}}, cin};
        ar_res = sum[WIDTH-1:0];
        ovf    = (A[WIDTH-1] == opb[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
`ifdef ALU_SAT_EN
        if (ovf) begin
            ar_res = A[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end
`endif
        alu_res   = A;
        alu_flags = flags_q;
        case (FunSel)
            FS_A:    alu_res = A;
            FS_B:    alu_res = B;
            FS_NOTA: alu_res = ~A;
            FS_NOTB: alu_res = ~B;
            FS_ADD, FS_ADC, FS_CMP: begin
                alu_res          = ar_res;
                alu_flags[FLG_C] = sum[WIDTH];
                alu_flags[FLG_O] = ovf;
            end
            FS_AND:  alu_res = A & B;
            FS_OR:   alu_res = A | B;
            FS_XOR:  alu_res = A ^ B;
            default: alu_res = A;
        endcase
        alu_flags[FLG_Z] = (alu_res == '0);
        alu_flags[FLG_N] = alu_res[WIDTH-1];
    end

    // Flags for a finishing shift step and for a zero-amount shift
    always_comb begin
        sh_flags        = flags_q;
        sh_flags[FLG_Z] = (step_nxt == '0);
        sh_flags[FLG_C] = step_out;
        sh_flags[FLG_N] = step_nxt[WIDTH-1];
        if ((step_op == FS_ASL) && fin_chg) begin
            sh_flags[FLG_O] = 1'b1;
        end
        z0_flags        = flags_q;
        z0_flags[FLG_Z] = (A == '0);
        z0_flags[FLG_N] = A[WIDTH-1];
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        fs_d    = fs_q;
        cnt_d   = cnt_q;
        chg_d   = chg_q;
        out_d   = out_q;
        flags_d = flags_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                state_d = ST_IDLE;
                if (START) begin
                    fs_d  = FunSel;
                    a_d   = A;
                    cnt_d = amt;
                    chg_d = 1'b0;
                    if (!is_shift(FunSel)) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                        out_d   = (FunSel == FS_CMP) ? out_q : alu_res;
                        flags_d = alu_flags;
                    end else if (amt == '0) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                        out_d   = A;
                        flags_d = z0_flags;
                    end else if (amt == SHAMT_W'(1)) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                        out_d   = step_nxt;
                        flags_d = sh_flags;
                    end else begin
                        state_d = ST_SHIFT;
                        busy_d  = 1'b1;
                        a_d     = step_nxt;
                        chg_d   = step_chg;
                        cnt_d   = amt - SHAMT_W'(1);
                    end
                end
            end
            ST_SHIFT: begin
                a_d   = step_nxt;
                chg_d = fin_chg;
                cnt_d = cnt_q - SHAMT_W'(1);
                if (cnt_q == SHAMT_W'(1)) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                    out_d   = step_nxt;
                    flags_d = sh_flags;
                end else begin
                    busy_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers; reset discards any op in flight
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            fs_q    <= '0;
            cnt_q   <= '0;
            chg_q   <= 1'b0;
            out_q   <= '0;
            flags_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            fs_q    <= fs_d;
            cnt_q   <= cnt_d;
            chg_q   <= chg_d;
            out_q   <= out_d;
            flags_q <= flags_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign OutALU = out_q;
    assign ZCNO   = flags_q;
    assign BUSY   = busy_q;
    assign DONE   = done_q;

endmodule
